// File: rtl/mem_arbiter_if.sv
// Cache-to-memory line transaction types and the bus bundle around the arbiter.
// The slave modport is the arbiter's view; master is the caches/memory side.
package mem_arbiter_pkg;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] w_data;
        logic         req;
        logic         w_en;
    } type_cache2mem_s;

    typedef struct packed {
        logic [127:0] r_data;
        logic         ack;
    } type_mem2cache_s;

endpackage

interface mem_arbiter_if;

    mem_arbiter_pkg::type_cache2mem_s icache2mem_i;
    mem_arbiter_pkg::type_mem2cache_s mem2icache_o;
    mem_arbiter_pkg::type_cache2mem_s dcache2mem_i;
    mem_arbiter_pkg::type_mem2cache_s mem2dcache_o;
    mem_arbiter_pkg::type_cache2mem_s arb2mem_o;
    mem_arbiter_pkg::type_mem2cache_s mem2arb_i;

    modport slave (
        input  icache2mem_i,
        input  dcache2mem_i,
        input  mem2arb_i,
        output mem2icache_o,
        output mem2dcache_o,
        output arb2mem_o
    );

    modport master (
        output icache2mem_i,
        output dcache2mem_i,
        output mem2arb_i,
        input  mem2icache_o,
        input  mem2dcache_o,
        input  arb2mem_o
    );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging icache and dcache line requests onto one memory
// port, with one outstanding transaction at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    typedef enum logic {
        ICACHE,
        DCACHE
    } port_e;

    state_e state_q, state_d;
    port_e  grant_q, grant_d;
    port_e  lastGrant_q, lastGrant_d;

    logic iReq;
    logic dReq;

    assign iReq = bus.icache2mem_i.req;
    assign dReq = bus.dcache2mem_i.req;

    // Reset leaves lastGrant at ICACHE so the first tie goes to the dcache.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            grant_q     <= ICACHE;
            lastGrant_q <= ICACHE;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // Memory request is gated by the registered state, so a client req never
    // reaches memory combinationally; only the memory response path is combinational.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        lastGrant_d      = lastGrant_q;
        bus.arb2mem_o    = '0;
        bus.mem2icache_o = '0;
        bus.mem2dcache_o = '0;

        case (state_q)
            IDLE: begin
                if (iReq || dReq) begin
                    state_d = BUSY;
                    if (iReq && dReq) begin
                        grant_d = (lastGrant_q == ICACHE) ? DCACHE : ICACHE;
                    end else if (iReq) begin
                        grant_d = ICACHE;
                    end else begin
                        grant_d = DCACHE;
                    end
                end
            end

            BUSY: begin
                // The instruction cache never writes, whatever its w_en says.
                if (grant_q == ICACHE) begin
                    bus.arb2mem_o      = bus.icache2mem_i;
                    bus.arb2mem_o.w_en = 1'b0;
                end else begin
                    bus.arb2mem_o = bus.dcache2mem_i;
                end
                bus.arb2mem_o.req = 1'b1;

                if (bus.mem2arb_i.ack) begin
                    if (grant_q == ICACHE) begin
                        bus.mem2icache_o = bus.mem2arb_i;
                    end else begin
                        bus.mem2dcache_o = bus.mem2arb_i;
                    end
                    lastGrant_d = grant_q;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter, checked against a
// transaction-level round-robin model of the two clients and a memory.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    logic clk;
    logic rst_n;

    int assertCount = 0;
    int failCount   = 0;

    type_cache2mem_s icReq;
    type_cache2mem_s dcReq;
    int              lastServed;
    string           ackOrder;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic type_cache2mem_s mkReq(input logic req, input logic [31:0] addr,
                                              input logic [127:0] data, input logic wen);
        type_cache2mem_s r;
        r.addr   = addr;
        r.w_data = data;
        r.req    = req;
        r.w_en   = wen;
        return r;
    endfunction

    function automatic type_mem2cache_s mkRsp(input logic [127:0] data, input logic ack);
        type_mem2cache_s r;
        r.r_data = data;
        r.ack    = ack;
        return r;
    endfunction

    // What memory should see while a port owns the bus.
    function automatic type_cache2mem_s expForward(input int port, input type_cache2mem_s f);
        type_cache2mem_s r;
        r     = f;
        r.req = 1'b1;
        if (port == PORT_I) r.w_en = 1'b0;
        return r;
    endfunction

    function automatic type_cache2mem_s randReq();
        return mkReq(1'b1, $urandom(), rand128(), $urandom_range(0, 1) == 1);
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input type_cache2mem_s ic, input type_cache2mem_s dc,
                                 input type_mem2cache_s mem);
        bus.icache2mem_i = ic;
        bus.dcache2mem_i = dc;
        bus.mem2arb_i    = mem;
        #1;
    endtask

    task automatic checkOutput(input string tag, input type_cache2mem_s observed,
                               input type_cache2mem_s expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkResponse(input string tag, input type_mem2cache_s observed,
                                 input type_mem2cache_s expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One transaction: entered in the IDLE cycle, leaves in the next IDLE cycle.
    // mode 0: plain; mode 1: random extras; mode 2: idle client raises req in first busy cycle.
    task automatic runRound(input int latency, input int mode);
        int              winner;
        int              loser;
        type_mem2cache_s rsp;
        type_mem2cache_s expI;
        type_mem2cache_s expD;
        type_cache2mem_s winFields;

        rsp = mkRsp(rand128(), (mode == 1) && ($urandom_range(0, 3) == 0));
        applyStimulus(icReq, dcReq, rsp);
        checkOutput("idle_arb", bus.arb2mem_o, '0);
        checkResponse("idle_icache_rsp", bus.mem2icache_o, '0);
        checkResponse("idle_dcache_rsp", bus.mem2dcache_o, '0);

        if (icReq.req && dcReq.req) winner = 1 - lastServed;
        else if (icReq.req)         winner = PORT_I;
        else                        winner = PORT_D;
        loser = 1 - winner;

        for (int c = 1; c <= latency; c++) begin
            nextCycle();
            if ((mode == 2 && c == 1) || (mode == 1 && $urandom_range(0, 3) == 0)) begin
                if (loser == PORT_I && !icReq.req) icReq = randReq();
                if (loser == PORT_D && !dcReq.req) dcReq = randReq();
            end
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                if (winner == PORT_I) icReq.req = 1'b0;
                else                  dcReq.req = 1'b0;
            end
            winFields = (winner == PORT_I) ? icReq : dcReq;
            rsp = mkRsp(rand128(), c == latency);
            applyStimulus(icReq, dcReq, rsp);

            expI = '0;
            expD = '0;
            if (c == latency && winner == PORT_I) expI = rsp;
            if (c == latency && winner == PORT_D) expD = rsp;
            checkOutput("busy_arb", bus.arb2mem_o, expForward(winner, winFields));
            checkResponse("busy_icache_rsp", bus.mem2icache_o, expI);
            checkResponse("busy_dcache_rsp", bus.mem2dcache_o, expD);
            if (c == latency) begin
                if (bus.mem2dcache_o.ack === 1'b1)      ackOrder = {ackOrder, "D"};
                else if (bus.mem2icache_o.ack === 1'b1) ackOrder = {ackOrder, "I"};
            end
        end

        lastServed = winner;
        if (winner == PORT_I) icReq.req = 1'b0;
        else                  dcReq.req = 1'b0;
        nextCycle();
    endtask

    initial begin
        int winner;

        rst_n      = 1'b0;
        lastServed = PORT_I;
        ackOrder   = "";
        icReq      = mkReq(1'b1, 32'h0000_1000, rand128(), 1'b0);
        dcReq      = mkReq(1'b1, 32'h0000_2000, rand128(), 1'b1);
        applyStimulus(icReq, dcReq, mkRsp(rand128(), 1'b1));

        // Reset asserted before any clock edge, both clients requesting.
        rst_n = 1'b1;
        #1;
        checkOutput("reset_async_arb", bus.arb2mem_o, '0);
        checkResponse("reset_async_icache", bus.mem2icache_o, '0);
        checkResponse("reset_async_dcache", bus.mem2dcache_o, '0);
        nextCycle();
        applyStimulus(icReq, dcReq, mkRsp(rand128(), 1'b1));
        checkOutput("reset_held_arb", bus.arb2mem_o, '0);
        checkResponse("reset_held_icache", bus.mem2icache_o, '0);
        checkResponse("reset_held_dcache", bus.mem2dcache_o, '0);
        rst_n = 1'b0;

        // Continuous contention: strict alternation starting with the dcache.
        for (int t = 0; t < 6; t++) runRound(1, 2);
        assertCount++;
        assert (ackOrder == "DIDIDI") else begin
            failCount++;
            $error("[TB] FAIL grant_order observed=%s expected=DIDIDI", ackOrder);
        end

        // Single icache read asking to write: memory must see a read.
        dcReq.req = 1'b0;
        icReq     = mkReq(1'b1, 32'h0000_0100, rand128(), 1'b1);
        runRound(1, 0);

        // Dcache line writeback.
        dcReq = mkReq(1'b1, 32'h0000_0200, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b1);
        runRound(1, 0);

        // Icache arrives while the dcache owns the bus, then gets the next slot.
        dcReq = mkReq(1'b1, 32'h0000_0300, rand128(), 1'b0);
        runRound(2, 2);
        runRound(1, 0);

        // Reset in the middle of a transaction, with memory acking that cycle.
        icReq  = mkReq(1'b1, $urandom(), rand128(), 1'b0);
        dcReq  = mkReq(1'b1, $urandom(), rand128(), 1'b1);
        winner = 1 - lastServed;
        applyStimulus(icReq, dcReq, mkRsp(rand128(), 1'b0));
        checkOutput("rst_mid_idle_arb", bus.arb2mem_o, '0);
        nextCycle();
        applyStimulus(icReq, dcReq, mkRsp(rand128(), 1'b0));
        checkOutput("rst_mid_busy_arb", bus.arb2mem_o,
                    expForward(winner, (winner == PORT_I) ? icReq : dcReq));
        nextCycle();
        applyStimulus(icReq, dcReq, mkRsp(rand128(), 1'b1));
        rst_n = 1'b1;
        #1;
        checkOutput("rst_mid_arb", bus.arb2mem_o, '0);
        checkResponse("rst_mid_icache", bus.mem2icache_o, '0);
        checkResponse("rst_mid_dcache", bus.mem2dcache_o, '0);
        nextCycle();
        applyStimulus(icReq, dcReq, mkRsp(rand128(), 1'b1));
        checkOutput("rst_mid_held_arb", bus.arb2mem_o, '0);
        checkResponse("rst_mid_held_icache", bus.mem2icache_o, '0);
        checkResponse("rst_mid_held_dcache", bus.mem2dcache_o, '0);
        rst_n      = 1'b0;
        lastServed = PORT_I;
        ackOrder   = "";
        runRound(1, 0);
        assertCount++;
        assert (ackOrder == "D") else begin
            failCount++;
            $error("[TB] FAIL post_reset_grant observed=%s expected=D", ackOrder);
        end

        // Randomized traffic with variable memory latency.
        for (int r = 0; r < 40; r++) begin
            if (!icReq.req && $urandom_range(0, 1) == 1) icReq = randReq();
            if (!dcReq.req && $urandom_range(0, 1) == 1) dcReq = randReq();
            if (!icReq.req && !dcReq.req) begin
                if ($urandom_range(0, 1) == 1) icReq = randReq();
                else                           dcReq = randReq();
            end
            runRound($urandom_range(1, 3), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
